wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Write-side initiator for the 32×32 register file's single write port. Merges the in-order writeback stage (fixed priority, never stalls) with results from long-latency units (multiply/divide, delayed loads) held in a small in-order queue. It drives `RegWrite`/`WriteAddr`/`WriteData` into the register file and keeps a pending-write scoreboard so the hazard unit can stall dependent reads.

## Interface
- `DEPTH`, default 4: long-latency queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pipe_we`  in  1  writeback-stage write request; no handshake, always accepted.
- `pipe_addr`  in  5  writeback destination register.
- `pipe_data`  in  32  writeback data.
- `lq_valid`  in  1  long-latency result valid.
- `lq_ready`  out  1  queue can accept; transfer when `lq_valid && lq_ready` at a rising edge.
- `lq_addr`  in  5  long-latency destination register.
- `lq_data`  in  32  long-latency data.
- `RegWrite`  out  1  register-file write enable; registered.
- `WriteAddr`  out  5  register-file write address; registered.
- `WriteData`  out  32  register-file write data; registered.
- `ReadAddr1`, `ReadAddr2`  in  5 each  decode-stage read addresses; same nets as the register-file read addresses.
- `rf_data1`, `rf_data2`  in  32 each  raw register-file read data.
- `ReadData1`, `ReadData2`  out  32 each  read data as seen by decode; bypassed when bypass is compiled in.
- `busy1`, `busy2`  out  1 each  the addressed register has a pending write not yet visible on `ReadDataN`.

## Operation
- **Reset values.** While `reset` is high, all of the following hold: `RegWrite`=0, `WriteAddr`=0, `WriteData`=0, queue empty, `lq_ready`=0, `busy1`=`busy2`=0.
- **Queue.** Circular buffer of `{live, addr, data}` entries. `lq_ready` = not full; it is never a function of the same-cycle pop.
  - A push while full cannot occur, because `lq_ready` is low.
  - A push with `lq_addr`=0 is accepted and discarded. It is not stored.
- **Arbitration** each edge, in priority order:
  1. If `pipe_we` and `pipe_addr`≠0: the output register is loaded with the pipe write and `RegWrite`=1.
  2. Else, if the queue head is live: the output register is loaded with the head, `RegWrite`=1, and the head is popped.
  3. Else: `RegWrite`=0. `WriteAddr`/`WriteData` hold their previous values.
- **Dead entries.** A dead queue head is popped every cycle regardless of pipe activity and never asserts `RegWrite`. At most one entry pops per cycle.
- **`pipe_we` with `pipe_addr`=0** is a no-op and frees the port.
- **Squash rule (WAW ordering).** A pipe write is younger than every queued entry. When a pipe write to register R is accepted, every live entry with addr R is cleared to dead. A same-cycle push to R is stored dead.
- **Simultaneous push and pop** are allowed. Occupancy is unchanged.
- **Scoreboard.** `busyN`=1 iff `ReadAddrN`≠0 and a live queue entry has addr `ReadAddrN`. Bypass configuration extends this; see Configuration.
- **Register 0** is never busy, never written, and never bypassed.

## Timing
- Pipe write: accepted at edge k; `RegWrite` high during cycle k→k+1; the register file commits at edge k+1.
- Queue write: minimum latency from push edge to `RegWrite` high is 1 cycle, when the queue was empty and there is no pipe write.
- Starvation: a live head waits while `pipe_we` is continuously active. No fairness is provided; the hazard unit resolves this by stalling on `busyN`.
- `busyN` and `ReadDataN` are combinational from current state and `ReadAddrN`.
- Reset asserted mid-operation drops all queued writes, including any pending `RegWrite`.

## Configuration
- **`WB_BYPASS_EN` defined.** `ReadDataN` = `WriteData` when `RegWrite` and `WriteAddr`=`ReadAddrN`≠0; otherwise `rf_dataN`. The output register does not contribute to `busyN`.
- **`WB_BYPASS_EN` undefined.** `ReadDataN` = `rf_dataN`. `busyN` additionally asserts when `RegWrite` and `WriteAddr`=`ReadAddrN`≠0, which costs a one-cycle stall.

## Structure
- **Package `wb_pkg`:**
  - constants `REG_ADDR_W`=5, `DATA_W`=32, `ZERO_REG`=5'd0;
  - typedef `wb_entry_t` {live, addr, data}.
- **Sub-module `wb_queue`:** the circular buffer.
  - Push/pop ports, full/empty flags, head entry.
  - A squash input (valid + addr) that kills matching entries.
  - Two match-lookup ports returning "live entry present".
- The top level holds the arbitration logic, the output register, and the bypass mux.

## Test plan
- **Reset during activity.** 3 entries queued, `RegWrite`=1; assert `reset` → outputs 0, queue empty, `busy`=0 immediately. After release, `lq_ready`=1 next cycle.
- **Priority.**
  - Stimulus: push (r5, 0xAAAA); next cycle `pipe_we` (r7, 0x1234) for 2 cycles.
  - Response: `RegWrite` shows r7 twice, then r5/0xAAAA. `busy` for r5 is high until the edge it loads the output.
- **Squash.**
  - Stimulus: push (r9, 0x1111), blocked by pipe writes to r3; then `pipe_we` (r9, 0x2222).
  - Response: r9 gets only 0x2222; the dead entry pops without `RegWrite`. A same-cycle push+pipe write to r9 also yields only the pipe value.
- **Register 0.** `pipe_we` r0 plus live head (r4, 0x55) → r4 written that cycle. Push r0 → queue occupancy unchanged. `ReadAddr1`=0 → `ReadData1`=`rf_data1`, `busy1`=0.
- **Full queue.** Fill `DEPTH` entries with `pipe_we` held high → `lq_ready`=0, `lq_valid` held. Release `pipe_we` → one pop per cycle in FIFO order and `lq_ready` rises after the first pop.
- **Bypass.** `RegWrite` (r12, 0xDEAD), `ReadAddr2`=12, `rf_data2`=0 → with `WB_BYPASS_EN`: `ReadData2`=0xDEAD, `busy2`=0; without it: `ReadData2`=0, `busy2`=1.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// wb_pkg: shared widths, the queue entry layout and the arbitration select
// encoding for the register-file write arbiter.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Source loaded into the output register on a given edge.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_QUEUE
  } wb_sel_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: valid/ready handshake carrying long-latency results
// (multiply/divide, delayed loads) into the write arbiter's queue.
//   lq_valid  producer -> arbiter  result valid
//   lq_ready  arbiter  -> producer queue can accept
//   lq_addr   producer -> arbiter  destination register
//   lq_data   producer -> arbiter  result data
// Modports: master = producing unit, slave = arbiter.
interface wb_write_arbiter_if;
  import wb_pkg::*;

  logic                  lq_valid;
  logic                  lq_ready;
  logic [REG_ADDR_W-1:0] lq_addr;
  logic [DATA_W-1:0]     lq_data;

  modport master (output lq_valid, output lq_addr, output lq_data, input lq_ready);
  modport slave  (input lq_valid, input lq_addr, input lq_data, output lq_ready);

endinterface

// File: rtl/wb_write_arbiter_queue.sv
// wb_queue: in-order circular buffer of {live, addr, data} write entries.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, pushEntry     store pushEntry at the tail (caller guarantees !full)
//   pop                 retire the head (caller guarantees !empty)
//   squashValid/Addr    mark every live entry with this addr dead
//   lookupAddr1/2       match1/2 = some live entry holds this addr
//   full, empty, head   occupancy flags and the current head entry
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             pushEntry,
  input  logic                  pop,
  input  logic                  squashValid,
  input  logic [REG_ADDR_W-1:0] squashAddr,
  input  logic [REG_ADDR_W-1:0] lookupAddr1,
  input  logic [REG_ADDR_W-1:0] lookupAddr2,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic                  match1,
  output logic                  match2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  // Popped slots are cleared to dead so unoccupied slots never match;
  // this lets the lookups and the squash scan every slot unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (squashValid) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (mem[i].addr == squashAddr) begin
            mem[i].live <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[rdPtr].live <= 1'b0;
        rdPtr           <= rdPtr + PTR_W'(1);
      end
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem[i].live && (mem[i].addr == lookupAddr1)) match1 = 1'b1;
      if (mem[i].live && (mem[i].addr == lookupAddr2)) match2 = 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: single-write-port initiator for the 32x32 register file.
// The writeback stage has fixed priority; long-latency results wait in an
// in-order queue (wb_queue). A pending-write scoreboard drives busy1/busy2.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   pipe_we/pipe_addr/pipe_data     writeback-stage write, always accepted
//   lq (wb_write_arbiter_if.slave)  long-latency result handshake
//   RegWrite/WriteAddr/WriteData    registered register-file write port
//   ReadAddr1/2, rf_data1/2         decode read addresses, raw RF data
//   ReadData1/2                     read data seen by decode
//   busy1/busy2                     addressed register has a pending write
// Build option: define WB_BYPASS_EN to forward the output register onto
// ReadDataN instead of reporting it as busy.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0]     pipe_data,
  wb_write_arbiter_if.slave     lq,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] ReadAddr1,
  input  logic [REG_ADDR_W-1:0] ReadAddr2,
  input  logic [DATA_W-1:0]     rf_data1,
  input  logic [DATA_W-1:0]     rf_data2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic                  busy1,
  output logic                  busy2
);

  logic      pipeWrite;
  logic      qPush;
  logic      qPop;
  logic      qFull;
  logic      qEmpty;
  logic      qMatch1;
  logic      qMatch2;
  wb_entry_t qHead;
  wb_entry_t pushEntry;
  wb_sel_e   sel;
  logic      outHit1;
  logic      outHit2;

  assign pipeWrite = pipe_we && (pipe_addr != ZERO_REG);

  assign lq.lq_ready = !qFull && !reset;

  // Writes to r0 are accepted on the handshake but never stored.
  assign qPush = lq.lq_valid && lq.lq_ready && (lq.lq_addr != ZERO_REG);

  // A same-cycle pipe write to the same register is younger: store dead.
  assign pushEntry = '{live: !(pipeWrite && (pipe_addr == lq.lq_addr)),
                       addr: lq.lq_addr,
                       data: lq.lq_data};

  always_comb begin
    sel = SEL_NONE;
    if (pipeWrite) begin
      sel = SEL_PIPE;
    end else if (!qEmpty && qHead.live) begin
      sel = SEL_QUEUE;
    end
  end

  // Dead heads drain every cycle, independent of pipe activity.
  assign qPop = !qEmpty && (!qHead.live || (sel == SEL_QUEUE));

  wb_queue #(.DEPTH(DEPTH)) queue (
    .clk         (clk),
    .reset       (reset),
    .push        (qPush),
    .pushEntry   (pushEntry),
    .pop         (qPop),
    .squashValid (pipeWrite),
    .squashAddr  (pipe_addr),
    .lookupAddr1 (ReadAddr1),
    .lookupAddr2 (ReadAddr2),
    .full        (qFull),
    .empty       (qEmpty),
    .head        (qHead),
    .match1      (qMatch1),
    .match2      (qMatch2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      case (sel)
        SEL_PIPE: begin
          RegWrite  <= 1'b1;
          WriteAddr <= pipe_addr;
          WriteData <= pipe_data;
        end
        SEL_QUEUE: begin
          RegWrite  <= 1'b1;
          WriteAddr <= qHead.addr;
          WriteData <= qHead.data;
        end
        default: RegWrite <= 1'b0;
      endcase
    end
  end

  assign outHit1 = RegWrite && (WriteAddr == ReadAddr1) && (ReadAddr1 != ZERO_REG);
  assign outHit2 = RegWrite && (WriteAddr == ReadAddr2) && (ReadAddr2 != ZERO_REG);

`ifdef WB_BYPASS_EN
  assign ReadData1 = outHit1 ? WriteData : rf_data1;
  assign ReadData2 = outHit2 ? WriteData : rf_data2;
  assign busy1     = qMatch1 && (ReadAddr1 != ZERO_REG);
  assign busy2     = qMatch2 && (ReadAddr2 != ZERO_REG);
`else
  assign ReadData1 = rf_data1;
  assign ReadData2 = rf_data2;
  assign busy1     = (qMatch1 && (ReadAddr1 != ZERO_REG)) || outHit1;
  assign busy2     = (qMatch2 && (ReadAddr2 != ZERO_REG)) || outHit2;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter (DEPTH=4). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on rising edges.
// Honours WB_BYPASS_EN for the bypass-dependent expectations.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic [31:0] rf_data1, rf_data2;
  logic [31:0] ReadData1, ReadData2;
  logic        busy1, busy2;

  int nChecks = 0;
  int nPass   = 0;

  wb_write_arbiter_if lqIf ();

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .pipe_addr (pipe_addr),
    .pipe_data (pipe_data),
    .lq        (lqIf),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr1 (ReadAddr1),
    .ReadAddr2 (ReadAddr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    nChecks++; if (RegWrite !== 1'b0) $display("FAIL rst_RegWrite got %b want 0", RegWrite); else nPass++;
    nChecks++; if (WriteAddr !== 5'd0) $display("FAIL rst_WriteAddr got %0d want 0", WriteAddr); else nPass++;
    nChecks++; if (WriteData !== 32'd0) $display("FAIL rst_WriteData got %h want 0", WriteData); else nPass++;
    nChecks++; if (lqIf.lq_ready !== 1'b0) $display("FAIL rst_lq_ready got %b want 0", lqIf.lq_ready); else nPass++;
    nChecks++; if (busy1 !== 1'b0) $display("FAIL rst_busy1 got %b want 0", busy1); else nPass++;
    @(negedge clk); reset = 1'b0; #1;
    nChecks++; if (lqIf.lq_ready !== 1'b1) $display("FAIL rel_lq_ready got %b want 1", lqIf.lq_ready); else nPass++;
    // queue three entries behind a steady pipe write
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33;
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd10; lqIf.lq_data = 32'hA0;
    @(negedge clk); lqIf.lq_addr = 5'd11; lqIf.lq_data = 32'hA1;
    @(negedge clk); lqIf.lq_addr = 5'd12; lqIf.lq_data = 32'hA2;
    @(negedge clk); lqIf.lq_valid = 1'b0; ReadAddr1 = 5'd11; #1;
    nChecks++; if (busy1 !== 1'b1) $display("FAIL act_busy1 got %b want 1", busy1); else nPass++;
    nChecks++; if (RegWrite !== 1'b1) $display("FAIL act_RegWrite got %b want 1", RegWrite); else nPass++;
    nChecks++; if (WriteAddr !== 5'd3) $display("FAIL act_WriteAddr got %0d want 3", WriteAddr); else nPass++;
    reset = 1'b1; #1;
    nChecks++; if (RegWrite !== 1'b0) $display("FAIL mid_RegWrite got %b want 0", RegWrite); else nPass++;
    nChecks++; if (WriteAddr !== 5'd0) $display("FAIL mid_WriteAddr got %0d want 0", WriteAddr); else nPass++;
    nChecks++; if (WriteData !== 32'd0) $display("FAIL mid_WriteData got %h want 0", WriteData); else nPass++;
    nChecks++; if (busy1 !== 1'b0) $display("FAIL mid_busy1 got %b want 0", busy1); else nPass++;
    nChecks++; if (lqIf.lq_ready !== 1'b0) $display("FAIL mid_lq_ready got %b want 0", lqIf.lq_ready); else nPass++;
    @(negedge clk); reset = 1'b0; pipe_we = 1'b0;
    @(negedge clk); #1;
    nChecks++; if (lqIf.lq_ready !== 1'b1) $display("FAIL post_lq_ready got %b want 1", lqIf.lq_ready); else nPass++;
    nChecks++; if (RegWrite !== 1'b0) $display("FAIL post_RegWrite got %b want 0", RegWrite); else nPass++;
    nChecks++; if (busy1 !== 1'b0) $display("FAIL post_busy1 got %b want 0", busy1); else nPass++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd5; lqIf.lq_data = 32'hAAAA; ReadAddr1 = 5'd5;
    @(negedge clk);
    lqIf.lq_valid = 1'b0; pipe_we = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h1234; #1;
    nChecks++; if (busy1 !== 1'b1) $display("FAIL pri_busy_q got %b want 1", busy1); else nPass++;
    nChecks++; if (RegWrite !== 1'b0) $display("FAIL pri_idle got %b want 0", RegWrite); else nPass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd7 || WriteData !== 32'h1234)
        $display("FAIL pri_pipe%0d got %b/%0d/%h want 1/7/1234", i, RegWrite, WriteAddr, WriteData); else nPass++;
      nChecks++; if (busy1 !== 1'b1) $display("FAIL pri_busy_wait%0d got %b want 1", i, busy1); else nPass++;
    end
    pipe_we = 1'b0;
    @(negedge clk); #1;
    nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'hAAAA)
      $display("FAIL pri_queue got %b/%0d/%h want 1/5/aaaa", RegWrite, WriteAddr, WriteData); else nPass++;
`ifdef WB_BYPASS_EN
    nChecks++; if (busy1 !== 1'b0) $display("FAIL pri_busy_out got %b want 0", busy1); else nPass++;
    nChecks++; if (ReadData1 !== 32'hAAAA) $display("FAIL pri_bypass got %h want aaaa", ReadData1); else nPass++;
`else
    nChecks++; if (busy1 !== 1'b1) $display("FAIL pri_busy_out got %b want 1", busy1); else nPass++;
`endif
    @(negedge clk); #1;
    nChecks++; if (RegWrite !== 1'b0 || WriteAddr !== 5'd5)
      $display("FAIL pri_after got %b/%0d want 0/5", RegWrite, WriteAddr); else nPass++;
    nChecks++; if (busy1 !== 1'b0) $display("FAIL pri_busy_done got %b want 0", busy1); else nPass++;
  endtask

  task automatic test_squash();
    @(negedge clk);
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd9; lqIf.lq_data = 32'h1111; ReadAddr1 = 5'd9;
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33;
    @(negedge clk); lqIf.lq_valid = 1'b0; #1;
    nChecks++; if (busy1 !== 1'b1) $display("FAIL sq_busy got %b want 1", busy1); else nPass++;
    @(negedge clk); pipe_addr = 5'd9; pipe_data = 32'h2222;
    @(negedge clk); pipe_we = 1'b0; #1;
    nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd9 || WriteData !== 32'h2222)
      $display("FAIL sq_pipe got %b/%0d/%h want 1/9/2222", RegWrite, WriteAddr, WriteData); else nPass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      nChecks++; if (RegWrite !== 1'b0 || WriteData !== 32'h2222)
        $display("FAIL sq_dead%0d got %b/%h want 0/2222", i, RegWrite, WriteData); else nPass++;
    end
    nChecks++; if (busy1 !== 1'b0) $display("FAIL sq_busy_clr got %b want 0", busy1); else nPass++;
    // push and pipe write to the same register on the same edge
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd9; lqIf.lq_data = 32'h3333;
    pipe_we = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h4444;
    @(negedge clk); lqIf.lq_valid = 1'b0; pipe_we = 1'b0; #1;
    nChecks++; if (RegWrite !== 1'b1 || WriteData !== 32'h4444)
      $display("FAIL sq_same got %b/%h want 1/4444", RegWrite, WriteData); else nPass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      nChecks++; if (RegWrite !== 1'b0 || WriteData !== 32'h4444)
        $display("FAIL sq_same_dead%0d got %b/%h want 0/4444", i, RegWrite, WriteData); else nPass++;
    end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd4; lqIf.lq_data = 32'h55;
    @(negedge clk);
    lqIf.lq_valid = 1'b0; pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h99;
    @(negedge clk); pipe_we = 1'b0; #1;
    nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd4 || WriteData !== 32'h55)
      $display("FAIL r0_pipe got %b/%0d/%h want 1/4/55", RegWrite, WriteAddr, WriteData); else nPass++;
    lqIf.lq_valid = 1'b1; lqIf.lq_addr = 5'd0; lqIf.lq_data = 32'h77;
    @(negedge clk); lqIf.lq_valid = 1'b0;
    @(negedge clk); #1;
    nChecks++; if (RegWrite !== 1'b0 || WriteAddr !== 5'd4)
      $display("FAIL r0_push got %b/%0d want 0/4", RegWrite, WriteAddr); else nPass++;
    ReadAddr1 = 5'd0; rf_data1 = 32'hCAFE; #1;
    nChecks++; if (ReadData1 !== 32'hCAFE) $display("FAIL r0_read got %h want cafe", ReadData1); else nPass++;
    nChecks++; if (busy1 !== 1'b0) $display("FAIL r0_busy got %b want 0", busy1); else nPass++;
  endtask

  task automatic test_full();
    logic [31:0] expData;
    @(negedge clk);
    pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h20; lqIf.lq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lqIf.lq_addr = 5'(16 + i); lqIf.lq_data = 32'(256 + i); #1;
      nChecks++; if (lqIf.lq_ready !== 1'b1) $display("FAIL full_fill%0d got %b want 1", i, lqIf.lq_ready); else nPass++;
      @(negedge clk);
    end
    lqIf.lq_addr = 5'd20; lqIf.lq_data = 32'h104; #1;
    nChecks++; if (lqIf.lq_ready !== 1'b0) $display("FAIL full_ready got %b want 0", lqIf.lq_ready); else nPass++;
    nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd2) $display("FAIL full_pipe got %b/%0d want 1/2", RegWrite, WriteAddr); else nPass++;
    @(negedge clk); #1;
    nChecks++; if (lqIf.lq_ready !== 1'b0) $display("FAIL full_hold got %b want 0", lqIf.lq_ready); else nPass++;
    pipe_we = 1'b0;
    @(negedge clk); #1;
    nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd16 || WriteData !== 32'h100)
      $display("FAIL full_pop0 got %b/%0d/%h want 1/16/100", RegWrite, WriteAddr, WriteData); else nPass++;
    nChecks++; if (lqIf.lq_ready !== 1'b1) $display("FAIL full_rise got %b want 1", lqIf.lq_ready); else nPass++;
    @(negedge clk); lqIf.lq_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      #1; expData = 32'(256 + i);
      nChecks++; if (RegWrite !== 1'b1 || WriteAddr !== 5'(16 + i) || WriteData !== expData)
        $display("FAIL full_pop%0d got %b/%0d/%h want 1/%0d/%h", i, RegWrite, WriteAddr, WriteData, 16 + i, expData); else nPass++;
      @(negedge clk);
    end
    #1;
    nChecks++; if (RegWrite !== 1'b0) $display("FAIL full_drained got %b want 0", RegWrite); else nPass++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    pipe_we = 1'b1; pipe_addr = 5'd12; pipe_data = 32'hDEAD; ReadAddr2 = 5'd12; rf_data2 = 32'h0;
    @(negedge clk); pipe_we = 1'b0; #1;
`ifdef WB_BYPASS_EN
    nChecks++; if (ReadData2 !== 32'hDEAD) $display("FAIL byp_data got %h want dead", ReadData2); else nPass++;
    nChecks++; if (busy2 !== 1'b0) $display("FAIL byp_busy got %b want 0", busy2); else nPass++;
`else
    nChecks++; if (ReadData2 !== 32'h0) $display("FAIL byp_data got %h want 0", ReadData2); else nPass++;
    nChecks++; if (busy2 !== 1'b1) $display("FAIL byp_busy got %b want 1", busy2); else nPass++;
`endif
    ReadAddr2 = 5'd13; rf_data2 = 32'h5; #1;
    nChecks++; if (ReadData2 !== 32'h5) $display("FAIL byp_other got %h want 5", ReadData2); else nPass++;
    nChecks++; if (busy2 !== 1'b0) $display("FAIL byp_other_busy got %b want 0", busy2); else nPass++;
  endtask

  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    lqIf.lq_valid = 1'b0; lqIf.lq_addr = '0; lqIf.lq_data = '0;
    ReadAddr1 = '0; ReadAddr2 = '0; rf_data1 = '0; rf_data2 = '0;
    test_reset();
    test_priority();
    test_squash();
    test_reg0();
    test_full();
    test_bypass();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
